dice_craps_ctrl: RTL and testbench

//  Game sequencer for the two-die board. Debounces the roll button and spins two
//  1..6 dice while the button is held. Latches the sum on release, then runs the

---
 rtl/dice_craps_ctrl_pkg.sv | 30 +++
 rtl/dice_craps_ctrl_if.sv | 30 +++
 rtl/dice_craps_ctrl_debounce.sv | 51 +++++
 rtl/dice_craps_ctrl.sv | 126 ++++++++++++
 tb/tb_dice_craps_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dice_craps_ctrl_pkg.sv
// Shared types and constants for the two-die craps sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dice_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROLL1,
      S_EVAL1,
      S_POINT,
      S_ROLLN,
      S_EVALN,
      S_WIN,
      S_LOSE
   } craps_state_t;

   typedef logic [2:0] die_t;

   localparam logic [3:0] SUM_SEVEN  = 4'd7;
   localparam logic [3:0] SUM_ELEVEN = 4'd11;
   localparam logic [3:0] SUM_TWO    = 4'd2;
   localparam logic [3:0] SUM_THREE  = 4'd3;
   localparam logic [3:0] SUM_TWELVE = 4'd12;

   // One step of a die face: 1..6, then back to 1.
   function automatic die_t next_die(input die_t d);
      return (d == 3'd6) ? 3'd1 : d + 3'd1;
   endfunction

endpackage

// File: rtl/dice_craps_ctrl_if.sv
// Board-side bundle for the craps sequencer: raw button in, dice/score/LED outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are levels or single-cycle pulses.
// Ports: roll_btn (raw button), die_a/die_b, sum/sum_valid, point, roll_cnt,
//        win/lose, state_o. master = sequencer side, slave = board/display side.
interface dice_craps_ctrl_if;
   import dice_pkg::*;

   logic       roll_btn;
   die_t       die_a;
   die_t       die_b;
   logic [3:0] sum;
   logic       sum_valid;
   logic [3:0] point;
   logic [7:0] roll_cnt;
   logic       win;
   logic       lose;
   logic [2:0] state_o;

   modport master (
      input  roll_btn,
      output die_a, die_b, sum, sum_valid, point, roll_cnt, win, lose, state_o
   );

   modport slave (
      output roll_btn,
      input  die_a, die_b, sum, sum_valid, point, roll_cnt, win, lose, state_o
   );

endinterface

// File: rtl/dice_craps_ctrl_debounce.sv
// Two-flop synchronizer plus counter debounce for the roll push-button.
// Latency: 2 sync cycles + DB_LIMIT stable cycles before db_level/db_rise/db_fall move.
// Backpressure: none; db_rise/db_fall are single-cycle pulses on db_level edges.
// Ports: sys_clk, reset (async active-low), btn_raw (asynchronous input),
//        db_level (settled level), db_rise/db_fall (edge pulses, aligned with db_level).
module btn_debounce #(
   parameter int DB_LIMIT = 50000,
   parameter int DB_W     = 16
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic btn_raw,
   output logic db_level,
   output logic db_rise,
   output logic db_fall
);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] cnt;

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         db_level <= 1'b0;
         db_rise  <= 1'b0;
         db_fall  <= 1'b0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         db_rise <= 1'b0;
         db_fall <= 1'b0;
         if (sync2 != db_level) begin
            // cnt counts prior disagreeing cycles; the DB_LIMIT-th one flips the level.
            if (cnt == DB_W'(DB_LIMIT - 1)) begin
               cnt      <= '0;
               db_level <= sync2;
               db_rise  <= sync2;
               db_fall  <= ~sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dice_craps_ctrl.sv
// Craps game sequencer: debounced button spins two dice, release latches the roll, FSM scores it.
// Latency: db_fall at t -> sum/sum_valid at t+1, win/lose/point at t+2; db_rise at t -> roll state at t+1.
// Backpressure: none; presses outside IDLE/POINT/WIN/LOSE are dropped, not queued.
// Ports: sys_clk, reset (async active-low), bus (dice_craps_ctrl_if.master: roll_btn in;
//        die_a, die_b, sum, sum_valid, point, roll_cnt, win, lose, state_o out).
module dice_craps_ctrl
   import dice_pkg::*;
#(
   parameter int DB_LIMIT = 50000,
   parameter int DB_W     = 16
) (
   input  logic               sys_clk,
   input  logic               reset,
   dice_craps_ctrl_if.master  bus
);

   logic       db_level;
   logic       db_rise;
   logic       db_fall;
   logic [2:0] state;
   die_t       die_a;
   die_t       die_b;
   logic [3:0] sum;
   logic       sum_valid;
   logic [3:0] point;
   logic [7:0] roll_cnt;
   logic       press;
   logic       release_ev;
   logic       rolling;
   logic [3:0] dice_sum;

   btn_debounce #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W)
   ) u_debounce (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .btn_raw  (bus.roll_btn),
      .db_level (db_level),
      .db_rise  (db_rise),
      .db_fall  (db_fall)
   );

   // A press/release only counts when the settled level agrees with the edge pulse.
   assign press      = db_rise & db_level;
   assign release_ev = db_fall & ~db_level;
   assign rolling    = (state == S_ROLL1) || (state == S_ROLLN);
   assign dice_sum   = {1'b0, die_a} + {1'b0, die_b};

   // Dice behave as a two-digit base-6 counter: die_b carries when die_a wraps.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         die_a <= 3'd1;
         die_b <= 3'd1;
      end else if (rolling) begin
         die_a <= next_die(die_a);
         if (die_a == 3'd6) begin
            die_b <= next_die(die_b);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         sum       <= 4'd0;
         sum_valid <= 1'b0;
         point     <= 4'd0;
         roll_cnt  <= 8'd0;
      end else begin
         sum_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (press) state <= S_ROLL1;
            end
            S_ROLL1, S_ROLLN: begin
               if (release_ev) begin
                  sum       <= dice_sum;
                  sum_valid <= 1'b1;
                  if (roll_cnt != 8'hFF) roll_cnt <= roll_cnt + 8'd1;
                  state <= (state == S_ROLL1) ? S_EVAL1 : S_EVALN;
               end
            end
            S_EVAL1: begin
               if (sum == SUM_SEVEN || sum == SUM_ELEVEN) begin
                  state <= S_WIN;
               end else if (sum == SUM_TWO || sum == SUM_THREE || sum == SUM_TWELVE) begin
                  state <= S_LOSE;
               end else begin
                  point <= sum;
                  state <= S_POINT;
               end
            end
            S_POINT: begin
               if (press) state <= S_ROLLN;
            end
            S_EVALN: begin
               // Seven is never a point, so the point match is checked first safely.
               if (sum == point)          state <= S_WIN;
               else if (sum == SUM_SEVEN) state <= S_LOSE;
               else                       state <= S_POINT;
            end
            S_WIN, S_LOSE: begin
               // Point stays on display after the game ends; a new press starts fresh.
               if (press) begin
                  point    <= 4'd0;
                  roll_cnt <= 8'd0;
                  state    <= S_ROLL1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.die_a     = die_a;
   assign bus.die_b     = die_b;
   assign bus.sum       = sum;
   assign bus.sum_valid = sum_valid;
   assign bus.point     = point;
   assign bus.roll_cnt  = roll_cnt;
   assign bus.win       = (state == S_WIN);
   assign bus.lose      = (state == S_LOSE);
   assign bus.state_o   = state;

endmodule

// File: tb/tb_dice_craps_ctrl.sv
// Bench for dice_craps_ctrl: game-level reference model compared every cycle, plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_dice_craps_ctrl;

   localparam int DB = 4;

   // Game phases in the documented state encoding order.
   localparam int ST_IDLE = 0, ST_ROLL1 = 1, ST_EVAL1 = 2, ST_POINT = 3;
   localparam int ST_ROLLN = 4, ST_EVALN = 5, ST_WIN = 6, ST_LOSE = 7;

   logic sys_clk = 1'b0;
   logic reset   = 1'b0;
   int   n_chk   = 0;
   int   n_err   = 0;

   dice_craps_ctrl_if bus ();

   dice_craps_ctrl #(
      .DB_LIMIT (DB),
      .DB_W     (4)
   ) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model. Dice are one spin index k in 0..35: die_a = k%6+1, die_b = k/6+1.
   int m_s1, m_s2, m_lvl, m_run, m_rise, m_fall;
   int m_k, m_st, m_sum, m_sv, m_point, m_cnt;

   always @(posedge sys_clk or negedge reset) begin
      int pr, pf;
      if (!reset) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
         m_k = 0; m_st = ST_IDLE; m_sum = 0; m_sv = 0; m_point = 0; m_cnt = 0;
      end else begin
         pr   = m_rise;
         pf   = m_fall;
         m_sv = 0;
         case (m_st)
            ST_IDLE:  if (pr) m_st = ST_ROLL1;
            ST_POINT: if (pr) m_st = ST_ROLLN;
            ST_ROLL1, ST_ROLLN: begin
               if (pf) begin
                  m_sum = (m_k % 6 + 1) + (m_k / 6 + 1);
                  m_sv  = 1;
                  if (m_cnt < 255) m_cnt = m_cnt + 1;
                  m_st = (m_st == ST_ROLL1) ? ST_EVAL1 : ST_EVALN;
               end
               m_k = (m_k + 1) % 36;
            end
            ST_EVAL1: begin
               if (m_sum == 7 || m_sum == 11) m_st = ST_WIN;
               else if (m_sum == 2 || m_sum == 3 || m_sum == 12) m_st = ST_LOSE;
               else begin m_point = m_sum; m_st = ST_POINT; end
            end
            ST_EVALN: begin
               if (m_sum == m_point) m_st = ST_WIN;
               else if (m_sum == 7) m_st = ST_LOSE;
               else m_st = ST_POINT;
            end
            default: if (pr) begin m_point = 0; m_cnt = 0; m_st = ST_ROLL1; end
         endcase
         // Button path: settled level follows the synced input after DB disagreeing cycles.
         m_rise = 0;
         m_fall = 0;
         if (m_s2 != m_lvl) begin
            m_run = m_run + 1;
            if (m_run == DB) begin
               m_lvl  = m_s2;
               m_run  = 0;
               m_rise = m_lvl;
               m_fall = (m_lvl == 0) ? 1 : 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = bus.roll_btn;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      chk("die_a",     bus.die_a,     m_k % 6 + 1);
      chk("die_b",     bus.die_b,     m_k / 6 + 1);
      chk("sum",       bus.sum,       m_sum);
      chk("sum_valid", bus.sum_valid, m_sv);
      chk("point",     bus.point,     m_point);
      chk("roll_cnt",  bus.roll_cnt,  m_cnt);
      chk("win",       bus.win,       (m_st == ST_WIN) ? 1 : 0);
      chk("lose",      bus.lose,      (m_st == ST_LOSE) ? 1 : 0);
      chk("state_o",   bus.state_o,   m_st);
   end

   // Hold the button long enough that the latched roll lands on (ta,tb).
   // Held h cycles gives h-1 spin steps before the latch.
   task automatic roll(input int ta, input int tb, input bit mid);
      int n, h;
      n = ((tb - 1) * 6 + (ta - 1) - m_k + 36) % 36;
      h = n + 1;
      while (h < 14) h += 36;
      @(negedge sys_clk);
      bus.roll_btn = 1'b1;
      for (int i = 1; i <= h; i++) begin
         @(negedge sys_clk);
         if (mid && i == 10) begin
            chk("newgame_lose",  bus.lose,     0);
            chk("newgame_win",   bus.win,      0);
            chk("newgame_cnt",   bus.roll_cnt, 0);
            chk("newgame_state", bus.state_o,  ST_ROLL1);
         end
      end
      bus.roll_btn = 1'b0;
      repeat (12) @(negedge sys_clk);
   endtask

   initial begin
      // 1: reset with the button already held
      bus.roll_btn = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("rst_state", bus.state_o,   ST_IDLE);
      chk("rst_die_a", bus.die_a,     1);
      chk("rst_die_b", bus.die_b,     1);
      chk("rst_sum",   bus.sum,       0);
      chk("rst_sv",    bus.sum_valid, 0);
      reset = 1'b1;
      repeat (4) @(negedge sys_clk);
      chk("held_state", bus.state_o, ST_IDLE);
      chk("held_die_a", bus.die_a,   1);
      chk("held_die_b", bus.die_b,   1);
      reset        = 1'b0;
      bus.roll_btn = 1'b0;
      repeat (2) @(negedge sys_clk);
      reset = 1'b1;
      repeat (3) @(negedge sys_clk);

      // 2: natural seven
      roll(3, 4, 1'b0);
      chk("t2_sum",  bus.sum,      7);
      chk("t2_win",  bus.win,      1);
      chk("t2_lose", bus.lose,     0);
      chk("t2_pt",   bus.point,    0);
      chk("t2_cnt",  bus.roll_cnt, 1);

      // 3: craps on snake eyes
      roll(1, 1, 1'b1);
      chk("t3_sum",  bus.sum,      2);
      chk("t3_lose", bus.lose,     1);
      chk("t3_win",  bus.win,      0);
      chk("t3_cnt",  bus.roll_cnt, 1);

      // 4: point 4, miss with 6, hit with 4
      roll(2, 2, 1'b1);
      chk("t4_pt",    bus.point,    4);
      chk("t4_state", bus.state_o,  ST_POINT);
      roll(3, 3, 1'b0);
      chk("t4_state2", bus.state_o, ST_POINT);
      chk("t4_cnt2",   bus.roll_cnt, 2);
      chk("t4_pt2",    bus.point,    4);
      roll(1, 3, 1'b0);
      chk("t4_win", bus.win,      1);
      chk("t4_cnt3", bus.roll_cnt, 3);

      // 5: point 6, seven out
      roll(1, 5, 1'b0);
      chk("t5_pt",  bus.point, 6);
      roll(5, 2, 1'b0);
      chk("t5_lose", bus.lose,  1);
      chk("t5_pt2",  bus.point, 6);
      chk("t5_sum",  bus.sum,   7);

      // 6: short bounce is ignored
      @(negedge sys_clk);
      bus.roll_btn = 1'b1;
      repeat (2) @(negedge sys_clk);
      bus.roll_btn = 1'b0;
      repeat (12) @(negedge sys_clk);
      chk("t6_bounce_state", bus.state_o, ST_LOSE);

      // point 5, then chase with sixes until the roll counter saturates
      roll(2, 3, 1'b0);
      chk("t6_pt", bus.point, 5);
      for (int r = 0; r < 256; r++) roll(3, 3, 1'b0);
      chk("t6_sat",   bus.roll_cnt, 255);
      chk("t6_state", bus.state_o,  ST_POINT);

      // reset in the middle of a point roll, button still held
      @(negedge sys_clk);
      bus.roll_btn = 1'b1;
      repeat (10) @(negedge sys_clk);
      chk("t6_rolln", bus.state_o, ST_ROLLN);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_state", bus.state_o,   ST_IDLE);
      chk("t6_rst_sum",   bus.sum,       0);
      chk("t6_rst_sv",    bus.sum_valid, 0);
      chk("t6_rst_pt",    bus.point,     0);
      chk("t6_rst_cnt",   bus.roll_cnt,  0);
      chk("t6_rst_die_a", bus.die_a,     1);
      chk("t6_rst_die_b", bus.die_b,     1);
      repeat (3) @(negedge sys_clk);
      reset = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("t6_rearm_idle", bus.state_o, ST_IDLE);
      repeat (9) @(negedge sys_clk);
      chk("t6_rearm_roll", bus.state_o, ST_ROLL1);
      bus.roll_btn = 1'b0;
      repeat (15) @(negedge sys_clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
